// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch predictor: two-bit counter
// encoding, its reset state, and the performance-counter ceiling.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t        CTR_RESET    = WNT;
    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/bp_sat_cnt.sv
// Two-bit saturating counter next-state: steps toward the resolved outcome and
// sticks at SNT / ST.
module bp_sat_cnt
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        // NOTE: default assignment first so every path drives ctr_next and no latch is inferred.
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_pred_gshare.sv
// Gshare direction predictor for the five-stage pipeline: PHT lookup in F,
// prediction in D, training / misprediction repair in M, plus perf counters.
module branch_pred_gshare
    import bp_pkg::*;
#(
    parameter int PHT_IDX_W = 10,
    parameter int GHR_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        flushE,
    input  logic        flushM,
    input  logic [31:0] pcF,
    input  logic        branchD,
    input  logic        branchM,
    input  logic        actual_takeM,
    output logic        pred_takeD,
    output logic        pred_takeM,
    output logic        pred_resM,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int PHT_SIZE = 1 << PHT_IDX_W;

    ctr_t                 pht [PHT_SIZE];
    logic [GHR_W-1:0]     ghr;

    logic [PHT_IDX_W-1:0] idxF, idxD, idxE, idxM;
    logic [1:0]           ctrF, ctrM, ctrNextM;
    logic                 ctrMsbD, predTakeE;
    logic [GHR_W-1:0]     ghrD, ghrE, ghrM;
    logic                 shiftD;
    logic [31:0]          branchCnt, mispredCnt;
    logic                 unusedPcBits;

    assign unusedPcBits = ^{pcF[31:PHT_IDX_W+2], pcF[1:0]};

    assign idxF = pcF[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign ctrF = pht[idxF];
    assign ctrM = pht[idxM];

    assign pred_takeD = branchD & ctrMsbD;
    assign pred_resM  = branchM & (pred_takeM ^ actual_takeM);
    assign shiftD     = branchD & ~stallD & ~flushD;

    assign branch_cnt  = branchCnt;
    assign mispred_cnt = mispredCnt;

    // F->D: flush takes priority over stall.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            idxD    <= '0;
            ctrMsbD <= 1'b0;
            ghrD    <= '0;
        end else if (flushD) begin
            idxD    <= '0;
            ctrMsbD <= 1'b0;
            ghrD    <= '0;
        end else if (!stallD) begin
            idxD    <= idxF;
            ctrMsbD <= ctrF[1];
            ghrD    <= ghr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flushE) begin
            idxE      <= '0;
            predTakeE <= 1'b0;
            ghrE      <= '0;
        end else begin
            idxE      <= idxD;
            predTakeE <= pred_takeD;
            ghrE      <= ghrD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flushM) begin
            idxM       <= '0;
            pred_takeM <= 1'b0;
            ghrM       <= '0;
        end else begin
            idxM       <= idxE;
            pred_takeM <= predTakeE;
            ghrM       <= ghrE;
        end
    end

    // Repair from M wins over the speculative shift of the younger branch in D.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (pred_resM) begin
            ghr <= GHR_W'({ghrM, actual_takeM});
        end else if (shiftD) begin
            ghr <= GHR_W'({ghr, pred_takeD});
        end
    end

    bp_sat_cnt uSatCnt (
        .ctr      (ctrM),
        .taken    (actual_takeM),
        .ctr_next (ctrNextM)
    );

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the PHT is reset to WNT, so it must stay a flop array; RAM macros cannot be bulk-reset.
        if (!rst) begin
            for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CTR_RESET;
        end else if (branchM) begin
            pht[idxM] <= ctr_t'(ctrNextM);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchCnt  <= '0;
            mispredCnt <= '0;
        end else begin
            if (branchM && branchCnt != PERF_CNT_MAX)  branchCnt  <= branchCnt + 32'd1;
            if (pred_resM && mispredCnt != PERF_CNT_MAX) mispredCnt <= mispredCnt + 32'd1;
        end
    end

endmodule

// File: doc/branch_pred_gshare.md
# branch_pred_gshare

Gshare direction predictor serving the five-stage MIPS pipeline: answers the fetch-stage lookup, hands a taken/not-taken prediction to decode, and resolves the branch in memory stage, where it trains the counter and flags mispredictions back to the datapath's PC-select and hazard logic. The block owns the pattern history table (PHT), the speculative global history register (GHR), the per-stage prediction metadata, and two performance counters.

## Interface
- PHT_IDX_W, 10, PHT index width (2^PHT_IDX_W two-bit counters)
- GHR_W, 8, global history length; must satisfy 1 ≤ GHR_W ≤ PHT_IDX_W
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stallD  in  1  hold F→D metadata register
- flushD  in  1  clear F→D metadata register
- flushE  in  1  clear D→E metadata register
- flushM  in  1  clear E→M metadata register
- pcF  in  32  fetch PC
- branchD  in  1  decoded instruction is a conditional branch
- branchM  in  1  instruction in M is a conditional branch
- actual_takeM  in  1  resolved outcome in M
- pred_takeD  out  1  prediction for the branch in D
- pred_takeM  out  1  prediction that travelled with the branch now in M
- pred_resM  out  1  misprediction in M (1 = wrong)
- branch_cnt  out  32  resolved branches, saturating
- mispred_cnt  out  32  mispredictions, saturating

## Operation
- Index F: idxF = pcF[PHT_IDX_W+1:2] XOR zero-extended GHR (GHR in low bits).
- Lookup: ctrF = PHT[idxF], combinational read.
- F→D register holds {idx, ctr[1], ghr}: loads when ~stallD; cleared by flushD (clear wins over stall).
- pred_takeD = branchD & ctrD[1]; the stored ctr bit means nothing when branchD = 0.
- D→E register holds {idx, pred_take, ghr_ckpt}, clears on flushE. E→M register clears on flushM.
- Counter states: SNT=00, WNT=01, WT=10, ST=11. Saturating ±1 per resolution: increment on taken, decrement on not-taken.
- Speculative history: when branchD & ~stallD & ~flushD, GHR ← {GHR[GHR_W-2:0], pred_takeD}. ghr_ckpt is the pre-shift GHR latched with the branch.
- Resolve M, when branchM = 1:
  - PHT[idxM] trains toward actual_takeM.
  - pred_resM = (pred_takeM ≠ actual_takeM).
  - On misprediction, GHR ← {ghr_ckptM[GHR_W-2:0], actual_takeM}.
- pred_resM = 0 when branchM = 0.
- Performance counters:
  - branch_cnt increments on each cycle with branchM.
  - mispred_cnt increments on each cycle with pred_resM.
  - Both hold at 32'hFFFF_FFFF.
- Simultaneous events:
  - Repair in M overrides the speculative shift in D in the same cycle; the younger branch is flushed by the datapath.
  - PHT write in M and read in F of the same entry: F sees the pre-write value. There is no bypass.

## Timing
- Reset (rst=0, async):
  - All PHT entries = WNT; GHR = 0.
  - All stage registers = 0, so pred_takeD = pred_takeM = pred_resM = 0.
  - branch_cnt = mispred_cnt = 0.
  - Reset mid-operation discards in-flight metadata.
- Lookup to prediction: one cycle (F at edge n, pred_takeD valid after edge n+1).
- pred_resM is combinational from the M register and actual_takeM in the same cycle. The PHT, GHR and counter updates commit at the next edge.
- Metadata latency D→M is two edges, aligned with the datapath pipeline registers. There is no stall on E or M.

## Structure
- Package bp_pkg holds:
  - the counter state constants SNT/WNT/WT/ST;
  - the 2-bit counter type;
  - the reset counter value WNT;
  - the saturation limit constant for the 32-bit performance counters.
- Sub-module bp_sat_cnt: combinational 2-bit saturating next-state (ctr, taken → ctr_next). It is used by the PHT update.
- The PHT is a flop array with async reset. It is not inferred RAM, because reset initialisation is mandatory.

## Test plan
- Reset check: after reset, branchD=1 at any pcF → pred_takeD=0 (WNT). Both counters read 0 and GHR is 0.
- Training:
  - Input: branch at pcF=0x0040_0010 resolved taken twice with GHR held at 0 (no intervening D shift).
  - Required: third lookup gives pred_takeD=1. pred_resM=1 on the first resolution, 0 on the second; branch_cnt=2, mispred_cnt=1.
- Saturation: five not-taken resolutions on one entry, then one taken → next prediction still 0 (counter went WNT→SNT, then up to WNT).
- History repair:
  - Input: GHR=8'h05, predict taken at D (GHR becomes 8'h0B), resolve not-taken in M.
  - Required: GHR=8'h0A on the next edge, even when a branch in D asserts a shift in the same cycle.
- Stall and flush:
  - Input: stallD=1 with branchD=1 for 3 cycles.
  - Required: pred_takeD stable, GHR shifts only once (when stall drops).
  - Input: flushD and stallD together.
  - Required: D metadata cleared.
- Counter saturation: force branch_cnt to 32'hFFFF_FFFE, resolve two branches → reads 32'hFFFF_FFFF and holds.
